// File: rtl/general_defines.sv
// Shared definitions for the instruction-side front end: PC width,
// prediction queue default depth, the prediction record layout and the
// branch resolve unit state encoding.
package general_defines;

    localparam int INSTR_MEM_IDX_W  = 8;
    localparam int PRED_Q_DEPTH_DEF = 8;

    typedef struct packed {
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic                       hit;
        logic [INSTR_MEM_IDX_W-1:0] target;
    } pred_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction FIFO. Holds one pred_entry_t per fetched
// control-flow instruction until execute resolves it. A flush empties the
// queue in one edge and wins over a push or pop in the same cycle.
module pred_queue
    import general_defines::*;
#(
    parameter int DEPTH = PRED_Q_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    input  logic        flush,
    output pred_entry_t head_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pred_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               push_en;
    logic               pop_en;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_en   = push && !full && !flush;
    assign pop_en    = pop && !empty && !flush;
    assign head_data = mem[head];

    // Storage write at the tail; no reset needed since count guards reads.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_en) begin
                head <= head + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-time BTB predictions, compares them
// against execute-time outcomes in program order, redirects fetch on a
// mispredict and writes the BTB.
// Optional macro BRU_UPDATE_FILTER_EN: when defined, taken branches that
// the BTB already predicted with the right target do not rewrite the BTB.
module branch_resolve_unit
    import general_defines::*;
#(
    parameter int PRED_Q_DEPTH = PRED_Q_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic [INSTR_MEM_IDX_W-1:0] pred_pc,
    input  logic                       pred_hit,
    input  logic [INSTR_MEM_IDX_W-1:0] pred_target,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [INSTR_MEM_IDX_W-1:0] res_target,
    output logic                       res_ready,
    output logic                       redirect_valid,
    output logic [INSTR_MEM_IDX_W-1:0] redirect_pc,
    output logic                       update_valid,
    output logic [INSTR_MEM_IDX_W-1:0] update_pc,
    output logic [INSTR_MEM_IDX_W-1:0] update_target,
    output logic [15:0]                mispredict_cnt
);

    bru_state_t                 state;
    pred_entry_t                push_rec;
    pred_entry_t                head_rec;
    logic                       q_full;
    logic                       q_empty;
    logic                       do_push;
    logic                       do_pop;
    logic                       mispredict;
    logic                       do_update;
    logic [INSTR_MEM_IDX_W-1:0] seq_pc;
    logic [INSTR_MEM_IDX_W-1:0] predicted_pc;
    logic [INSTR_MEM_IDX_W-1:0] actual_pc;

    assign push_rec   = '{pc: pred_pc, hit: pred_hit, target: pred_target};
    assign pred_ready = !rst && (state == RUN) && !q_full;
    assign res_ready  = !rst && (state == RUN) && !q_empty;
    assign do_push    = pred_valid && pred_ready;
    assign do_pop     = res_valid && res_ready;

    pred_queue #(
        .DEPTH(PRED_Q_DEPTH)
    ) u_pred_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .push_data(push_rec),
        .pop      (do_pop),
        .flush    (mispredict),
        .head_data(head_rec),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Compare the oldest prediction with the resolved outcome and decide on redirect/BTB write.
    always_comb begin
        seq_pc       = head_rec.pc + INSTR_MEM_IDX_W'(1);
        predicted_pc = head_rec.hit ? head_rec.target : seq_pc;
        actual_pc    = res_taken ? res_target : seq_pc;
        mispredict   = do_pop && (predicted_pc != actual_pc);
`ifdef BRU_UPDATE_FILTER_EN
        do_update    = do_pop && res_taken &&
                       (!head_rec.hit || (head_rec.target != res_target));
`else
        do_update    = do_pop && res_taken;
`endif
    end

    // RUN/FLUSH sequencing: a mispredicted pop costs exactly one bubble cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= mispredict ? FLUSH : RUN;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Registered redirect and BTB update pulses plus the saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            update_valid   <= 1'b0;
            update_pc      <= '0;
            update_target  <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= mispredict;
            update_valid   <= do_update;
            if (mispredict) begin
                redirect_pc <= actual_pc;
                if (mispredict_cnt != 16'hFFFF) begin
                    mispredict_cnt <= mispredict_cnt + 16'd1;
                end
            end
            if (do_update) begin
                update_pc     <= head_rec.pc;
                update_target <= res_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a table of single
// push/resolve vectors plus hand-written flush, full-queue and reset
// sequences. Honours BRU_UPDATE_FILTER_EN for the expected BTB writes.
module tb_branch_resolve_unit;
    import general_defines::*;

    localparam int W = INSTR_MEM_IDX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         pred_valid;
    logic [W-1:0] pred_pc;
    logic         pred_hit;
    logic [W-1:0] pred_target;
    logic         pred_ready;
    logic         res_valid;
    logic         res_taken;
    logic [W-1:0] res_target;
    logic         res_ready;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         update_valid;
    logic [W-1:0] update_pc;
    logic [W-1:0] update_target;
    logic [15:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [W-1:0] pc;
        logic         hit;
        logic [W-1:0] tgt;
        logic         taken;
        logic [W-1:0] rtgt;
        logic         exp_redir;
        logic [W-1:0] exp_rpc;
        logic         exp_upd_plain;
        logic         exp_upd_filt;
    } vec_t;

    vec_t vecs [7];

    branch_resolve_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_hit      (pred_hit),
        .pred_target   (pred_target),
        .pred_ready    (pred_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .res_ready     (res_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs starting at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic pv, input logic [W-1:0] pc, input logic hit,
                                 input logic [W-1:0] tgt, input logic rv, input logic taken,
                                 input logic [W-1:0] rtgt);
        pred_valid  = pv;
        pred_pc     = pc;
        pred_hit    = hit;
        pred_target = tgt;
        res_valid   = rv;
        res_taken   = taken;
        res_target  = rtgt;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic expUpdate(input logic plain, input logic filt);
`ifdef BRU_UPDATE_FILTER_EN
        return filt;
`else
        return plain;
`endif
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic eu;

        //            pc     hit tgt    taken rtgt   redir rpc    upd  updF
        vecs[0] = '{8'h10, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h20, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[2] = '{8'h30, 1'b1, 8'h50, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h44, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h60, 1'b1, 8'h70, 1'b1, 8'h90, 1'b1, 8'h90, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h05, 1'b1, 1'b1};

        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_hit = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset pred_ready", {31'd0, pred_ready}, 32'd0);
        checkOutput("reset res_ready", {31'd0, res_ready}, 32'd0);
        checkOutput("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("reset update_valid", {31'd0, update_valid}, 32'd0);
        checkOutput("reset mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset pred_ready", {31'd0, pred_ready}, 32'd1);
        checkOutput("post-reset res_ready", {31'd0, res_ready}, 32'd0);

        // Table: push one record, resolve it, then one idle cycle.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].pc, vecs[i].hit, vecs[i].tgt, 1'b0, 1'b0, '0);
            checkOutput($sformatf("v%0d res_ready after push", i), {31'd0, res_ready}, 32'd1);
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, vecs[i].taken, vecs[i].rtgt);
            eu = expUpdate(vecs[i].exp_upd_plain, vecs[i].exp_upd_filt);
            if (vecs[i].exp_redir) exp_cnt++;
            checkOutput($sformatf("v%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_redir});
            if (vecs[i].exp_redir)
                checkOutput($sformatf("v%0d redirect_pc", i), {24'd0, redirect_pc}, {24'd0, vecs[i].exp_rpc});
            checkOutput($sformatf("v%0d update_valid", i), {31'd0, update_valid}, {31'd0, eu});
            if (eu) begin
                checkOutput($sformatf("v%0d update_pc", i), {24'd0, update_pc}, {24'd0, vecs[i].pc});
                checkOutput($sformatf("v%0d update_target", i), {24'd0, update_target}, {24'd0, vecs[i].rtgt});
            end
            checkOutput($sformatf("v%0d mispredict_cnt", i), {16'd0, mispredict_cnt}, exp_cnt);
            checkOutput($sformatf("v%0d pred_ready", i), {31'd0, pred_ready}, {31'd0, !vecs[i].exp_redir});
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("v%0d redirect pulse end", i), {31'd0, redirect_valid}, 32'd0);
            checkOutput($sformatf("v%0d update pulse end", i), {31'd0, update_valid}, 32'd0);
            checkOutput($sformatf("v%0d idle pred_ready", i), {31'd0, pred_ready}, 32'd1);
            checkOutput($sformatf("v%0d idle res_ready", i), {31'd0, res_ready}, 32'd0);
        end

        // Hit but not taken behind three younger records; a same-cycle push is dropped.
        applyStimulus(1'b1, 8'h30, 1'b1, 8'h50, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("flush pre pred_ready", {31'd0, pred_ready}, 32'd1);
        applyStimulus(1'b1, 8'h99, 1'b0, '0, 1'b1, 1'b0, '0);
        exp_cnt++;
        checkOutput("flush redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("flush redirect_pc", {24'd0, redirect_pc}, 32'h31);
        checkOutput("flush update_valid", {31'd0, update_valid}, 32'd0);
        checkOutput("flush pred_ready", {31'd0, pred_ready}, 32'd0);
        checkOutput("flush res_ready", {31'd0, res_ready}, 32'd0);
        checkOutput("flush mispredict_cnt", {16'd0, mispredict_cnt}, exp_cnt);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("after flush pred_ready", {31'd0, pred_ready}, 32'd1);
        checkOutput("after flush res_ready (queue empty)", {31'd0, res_ready}, 32'd0);

        // Full queue: eight pushes, a rejected ninth, then eight in-order correct resolves.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, '0);
        checkOutput("full pred_ready", {31'd0, pred_ready}, 32'd0);
        checkOutput("full res_ready", {31'd0, res_ready}, 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, '0);
        checkOutput("full after 9th push pred_ready", {31'd0, pred_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, 8'hAB, 1'b1, 8'hBC, 1'b1, 1'b1, 8'(8'hC0 + i));
            eu = expUpdate(1'b1, 1'b0);
            checkOutput($sformatf("drain%0d redirect_valid", i), {31'd0, redirect_valid}, 32'd0);
            checkOutput($sformatf("drain%0d update_valid", i), {31'd0, update_valid}, {31'd0, eu});
            if (eu)
                checkOutput($sformatf("drain%0d update_pc", i), {24'd0, update_pc}, 32'h80 + i);
            checkOutput($sformatf("drain%0d res_ready", i), {31'd0, res_ready}, {31'd0, i < 7});
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("drained pred_ready", {31'd0, pred_ready}, 32'd1);
        checkOutput("drained mispredict_cnt", {16'd0, mispredict_cnt}, exp_cnt);

        // Reset mid-flight with a BTB update pulse pending.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 8'h20);
        checkOutput("pre-reset update_valid", {31'd0, update_valid}, {31'd0, expUpdate(1'b1, 1'b0)});
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("midrst pred_ready", {31'd0, pred_ready}, 32'd0);
        checkOutput("midrst res_ready", {31'd0, res_ready}, 32'd0);
        checkOutput("midrst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("midrst redirect_pc", {24'd0, redirect_pc}, 32'd0);
        checkOutput("midrst update_valid", {31'd0, update_valid}, 32'd0);
        checkOutput("midrst update_pc", {24'd0, update_pc}, 32'd0);
        checkOutput("midrst update_target", {24'd0, update_target}, 32'd0);
        checkOutput("midrst mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("after midrst res_ready", {31'd0, res_ready}, 32'd0);
        checkOutput("after midrst pred_ready", {31'd0, pred_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

- Tracks every control-flow instruction from fetch to execute.
  - Fetch records each such instruction and the BTB prediction made for it.
  - Execute resolves them in program order.
- On each resolution the unit compares predicted and actual next-PC.
  - On a mismatch it redirects fetch.
  - It drives the BTB's update port (`update_valid`/`update_pc`/`update_target`).
- It is the writer side of the BTB, sitting between fetch, the branch execution path and the BTB.

## Interface
Reset `rst` is synchronous and active-high; the clock is `clk`.

Parameters:
- `PRED_Q_DEPTH`, default 8: in-flight prediction queue depth; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `pred_valid`  in  1  fetch pushes a prediction record
- `pred_pc`  in  `INSTR_MEM_IDX_W`  PC of the control-flow instruction
- `pred_hit`  in  1  BTB hit at fetch (predicted taken)
- `pred_target`  in  `INSTR_MEM_IDX_W`  BTB target at fetch
- `pred_ready`  out  1  queue can accept a push
- `res_valid`  in  1  execute resolves the oldest record
- `res_taken`  in  1  actual direction
- `res_target`  in  `INSTR_MEM_IDX_W`  actual taken target
- `res_ready`  out  1  an oldest record is available to resolve
- `redirect_valid`  out  1  one-cycle fetch redirect pulse
- `redirect_pc`  out  `INSTR_MEM_IDX_W`  corrected next PC
- `update_valid`  out  1  BTB write strobe
- `update_pc`  out  `INSTR_MEM_IDX_W`  BTB write tag/PC
- `update_target`  out  `INSTR_MEM_IDX_W`  BTB write target
- `mispredict_cnt`  out  16  saturating mispredict count

## Operation
- **Push:** happens when `pred_valid && pred_ready`. The record {`pred_pc`, `pred_hit`, `pred_target`} is written at the tail.
- **Pop:** happens when `res_valid && res_ready`. The head record is consumed.
- **Next-PC rules:**
  - Predicted next PC = `pred_hit ? pred_target : pred_pc+1`.
  - Actual next PC = `res_taken ? res_target : pred_pc+1`.
  - `pred_pc+1` wraps modulo 2^`INSTR_MEM_IDX_W`.
- **Mispredict:** predicted next PC differs from actual next PC.
- **FSM states:**
  - RUN: normal operation.
  - FLUSH: entered on the edge that pops a mispredicted record; stays exactly one cycle, then returns to RUN.
- **On entering FLUSH:**
  - The whole queue is emptied: head = tail, count = 0.
  - A push in the same cycle is discarded.
  - `redirect_valid`=1 with `redirect_pc` = actual next PC.
  - `mispredict_cnt` increments, saturating at 0xFFFF.
- **In FLUSH:** `pred_ready`=0 and `res_ready`=0.
- **BTB update:**
  - A pop with `res_taken`=1 produces `update_valid`=1 with `update_pc` = record PC and `update_target` = `res_target`.
  - A not-taken pop never updates; the BTB has no invalidate.
- **Outputs when no pop:** `update_valid`=0.
- **Readiness:**
  - `pred_ready` = RUN && count < `PRED_Q_DEPTH`. There is no same-cycle pop bypass: a full queue rejects a push even while popping.
  - `res_ready` = RUN && count > 0.
- **Reset:** queue empty, state RUN. `pred_ready`=0 and `res_ready`=0 while `rst` is high. Every registered output is 0: `redirect_valid`, `redirect_pc`, `update_valid`, `update_pc`, `update_target`, `mispredict_cnt`.
- **Reset mid-operation:** discards all records and any pending redirect or update.

## Timing
- Push becomes visible at the head at the earliest on the following cycle; there is no empty bypass.
- Pop to outputs:
  - `update_*` and `redirect_*` are registered and appear the cycle after the pop edge.
  - Each is a single-cycle pulse.
- Throughput: one push and one pop per cycle, except the FLUSH bubble cycle.
- Head/tail pointers are `$clog2(PRED_Q_DEPTH)` bits and wrap naturally.
- Count is `$clog2(PRED_Q_DEPTH)+1` bits.

## Configuration
- Macro: `BRU_UPDATE_FILTER_EN`.
- **Defined:** a taken pop updates the BTB only if `!pred_hit || pred_target != res_target`. Correctly predicted taken branches generate no write, saving BTB write activity.
- **Undefined:** every taken pop updates the BTB.
- Redirect and counter behaviour are identical in both builds.

## Structure
- Shared package `general_defines` holds:
  - existing `INSTR_MEM_IDX_W`;
  - new `PRED_Q_DEPTH_DEF` (8);
  - typedef `pred_entry_t` {pc, hit, target};
  - enum `bru_state_t` {RUN, FLUSH}.
- One sub-module, `pred_queue`: parameterised FIFO of `pred_entry_t` with push, pop, flush, full, empty and count.
- Compare logic, FSM and output registers stay in `branch_resolve_unit`.

## Test plan
- **Correct taken hit:** push {pc=0x10, hit=1, target=0x40}, resolve taken target 0x40. Response: no redirect. `update_valid`=1 (0x10→0x40) without the filter; `update_valid`=0 with `BRU_UPDATE_FILTER_EN`.
- **Miss but taken:** push {0x20, hit=0}, resolve taken 0x80. Response, one cycle later: `redirect_valid`=1, `redirect_pc`=0x80, `update` 0x20→0x80, `mispredict_cnt`=1.
- **Hit but not taken:**
  - Push {0x30, hit=1, target=0x50}, then push 3 more records, then resolve 0x30 not-taken.
  - Response: `redirect_pc`=0x31, no update, queue count becomes 0.
  - Next cycle `pred_ready`=0; the cycle after, `pred_ready`=1.
- **Full queue:**
  - Push 8 records. Response: `pred_ready`=0, and a 9th push is ignored.
  - Resolve all 8 correctly. Response: `res_ready` drops after the 8th pop; the queue has wrapped.
- **PC wrap:** push {pc = all-ones, hit=1, target=0}, resolve not-taken. Response: `redirect_pc`=0 is not expected (actual 0 equals predicted 0), so no redirect and no update.
- **Reset mid-flight:** push 3 records, then assert `rst` for 1 cycle. Response: all outputs 0, `res_ready`=0, `mispredict_cnt`=0.
